// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the parametrised register file:
//   rf_state_t  - clear-sequencer state encoding (IDLE / CLEAR)
//   RF_DATA_W   - default register width
//   RF_ADDR_W   - default address width (DEPTH = 2**RF_ADDR_W)
// ---------------------------------------------------------------------------
package reg_file_pkg;

    // State kept as a plain vector with named constants so older code that
    // compares against raw encodings keeps working.
    typedef logic [0:0] rf_state_t;

    localparam rf_state_t IDLE  = 1'b0;
    localparam rf_state_t CLEAR = 1'b1;

    localparam int RF_DATA_W = 8;
    localparam int RF_ADDR_W = 3;

endpackage : reg_file_pkg

// File: rtl/reg_file_if.sv
// ---------------------------------------------------------------------------
// reg_file_if
// Bus bundle between the datapath (master) and the register file (slave).
//   WRITE        write enable, sampled at the rising clock edge
//   INADDRESS    write address
//   IN           write data
//   OUT1ADDRESS  read port 1 address
//   OUT2ADDRESS  read port 2 address
//   OUT1 / OUT2  combinational read data
//   BUSY         high while the register file clears itself after reset
// ---------------------------------------------------------------------------
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
);

    logic              WRITE;
    logic [ADDR_W-1:0] INADDRESS;
    logic [DATA_W-1:0] IN;
    logic [ADDR_W-1:0] OUT1ADDRESS;
    logic [ADDR_W-1:0] OUT2ADDRESS;
    logic [DATA_W-1:0] OUT1;
    logic [DATA_W-1:0] OUT2;
    logic              BUSY;

    modport master (
        output WRITE, INADDRESS, IN, OUT1ADDRESS, OUT2ADDRESS,
        input  OUT1, OUT2, BUSY
    );

    modport slave (
        input  WRITE, INADDRESS, IN, OUT1ADDRESS, OUT2ADDRESS,
        output OUT1, OUT2, BUSY
    );

endinterface : reg_file_if

// File: rtl/rf_read_port.sv
// ---------------------------------------------------------------------------
// rf_read_port
// One combinational read port of the register file. Applies, in priority
// order: clear-in-progress forcing to zero, the hardwired zero register,
// and the same-cycle write-to-read bypass.
//   mem_data  stored value at rd_addr
//   rd_addr   read address
//   wr_data   write data currently presented (IN)
//   wr_addr   write address currently presented (INADDRESS)
//   wr_en     write enable currently presented (WRITE)
//   busy      clear sequence running
//   rd_data   resulting read data
// ---------------------------------------------------------------------------
module rf_read_port #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_en,
    input  logic              busy,
    output logic [DATA_W-1:0] rd_data
);

    always_comb begin
        rd_data = mem_data;
        if (busy) begin
            rd_data = '0;
        end else if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            rd_data = '0;
        end else if ((BYPASS != 0) && wr_en && (rd_addr == wr_addr)) begin
            rd_data = wr_data;
        end
    end

endmodule : rf_read_port

// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
// Parametrised register file: 2**ADDR_W entries of DATA_W bits, one
// synchronous write port and two combinational read ports. After reset the
// array is cleared one entry per clock; BUSY is high for that whole sequence
// and writes are dropped while it runs.
//   CLK    clock, rising edge
//   RESET  synchronous, active-high reset (restarts the clear sequence)
//   bus    reg_file_if slave: WRITE/INADDRESS/IN, OUT1ADDRESS/OUT2ADDRESS,
//          OUT1/OUT2, BUSY
// Parameters: DATA_W, ADDR_W, BYPASS (same-cycle write-to-read forwarding),
//             ZERO_REG (entry 0 hardwired to zero).
// ---------------------------------------------------------------------------
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic      CLK,
    input  logic      RESET,
    reg_file_if.slave bus
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rf_state_t         state_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              user_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // BUSY comes straight from the state register.
    assign busy     = (state_reg == CLEAR);
    assign bus.BUSY = busy;

    // Clear sequencer. The terminal test is on LAST_ADDR so the pointer
    // never wraps past the top entry.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= CLEAR;
            ptr_reg   <= '0;
        end else if (state_reg == CLEAR) begin
            if (ptr_reg == LAST_ADDR) begin
                state_reg <= IDLE;
            end else begin
                ptr_reg <= ptr_reg + 1'b1;
            end
        end
    end

    // Datapath write, with entry 0 protected when it is hardwired.
    always_comb begin
        user_we = bus.WRITE;
        if ((ZERO_REG != 0) && (bus.INADDRESS == '0)) begin
            user_we = 1'b0;
        end
    end

    // Single array write port shared between the clear sequence and the
    // datapath; nothing is written while RESET is held.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.INADDRESS;
        mem_wdata = bus.IN;
        if (!RESET) begin
            if (busy) begin
                mem_we    = 1'b1;
                mem_waddr = ptr_reg;
                mem_wdata = '0;
            end else begin
                mem_we = user_we;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Two identical read ports.
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    assign rd_addr[0] = bus.OUT1ADDRESS;
    assign rd_addr[1] = bus.OUT2ADDRESS;
    assign bus.OUT1   = rd_data[0];
    assign bus.OUT2   = rd_data[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            rf_read_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .BYPASS   (BYPASS),
                .ZERO_REG (ZERO_REG)
            ) u_port (
                .mem_data (mem[rd_addr[gi]]),
                .rd_addr  (rd_addr[gi]),
                .wr_data  (bus.IN),
                .wr_addr  (bus.INADDRESS),
                .wr_en    (bus.WRITE),
                .busy     (busy),
                .rd_data  (rd_data[gi])
            );
        end
    endgenerate

endmodule : reg_file_param

// File: tb/tb_reg_file_param.sv
// ---------------------------------------------------------------------------
// tb_reg_file_param
// Directed bench for reg_file_param with three configurations:
//   A: 8x8,  BYPASS=1, ZERO_REG=0
//   B: 8x8,  BYPASS=0, ZERO_REG=1
//   C: 32x16, BYPASS=1, ZERO_REG=1
// ---------------------------------------------------------------------------
module tb_reg_file_param;

    logic CLK = 1'b0;
    logic rst_a, rst_b, rst_c;

    always #5 CLK = ~CLK;

    reg_file_if #(.DATA_W(8),  .ADDR_W(3)) bus_a ();
    reg_file_if #(.DATA_W(8),  .ADDR_W(3)) bus_b ();
    reg_file_if #(.DATA_W(16), .ADDR_W(5)) bus_c ();

    reg_file_param #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) dut_a (
        .CLK (CLK), .RESET (rst_a), .bus (bus_a.slave)
    );
    reg_file_param #(.DATA_W(8), .ADDR_W(3), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .CLK (CLK), .RESET (rst_b), .bus (bus_b.slave)
    );
    reg_file_param #(.DATA_W(16), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1)) dut_c (
        .CLK (CLK), .RESET (rst_c), .bus (bus_c.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock edge, then settle 1 time unit so outputs are sampled away
    // from the edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic write_a(input logic [2:0] addr, input logic [7:0] data);
        bus_a.WRITE     = 1'b1;
        bus_a.INADDRESS = addr;
        bus_a.IN        = data;
        tick();
        bus_a.WRITE     = 1'b0;
    endtask

    // Read every entry of A on both ports (port 2 in reverse order).
    task automatic check_all_a(input string tag, input logic [7:0] exp);
        for (int i = 0; i < 8; i++) begin
            bus_a.OUT1ADDRESS = 3'(i);
            bus_a.OUT2ADDRESS = 3'(7 - i);
            tick();
            chk({tag, "_p1"}, 16'(bus_a.OUT1), 16'(exp));
            chk({tag, "_p2"}, 16'(bus_a.OUT2), 16'(exp));
        end
    endtask

    initial begin
        bus_a.WRITE = 0; bus_a.INADDRESS = 0; bus_a.IN = 0;
        bus_a.OUT1ADDRESS = 0; bus_a.OUT2ADDRESS = 0;
        bus_b.WRITE = 0; bus_b.INADDRESS = 0; bus_b.IN = 0;
        bus_b.OUT1ADDRESS = 0; bus_b.OUT2ADDRESS = 0;
        bus_c.WRITE = 0; bus_c.INADDRESS = 0; bus_c.IN = 0;
        bus_c.OUT1ADDRESS = 0; bus_c.OUT2ADDRESS = 0;
        rst_a = 1; rst_b = 1; rst_c = 1;

        // Reset held for two edges.
        bus_a.OUT1ADDRESS = 3;
        tick(2);
        chk("rst_busy_a", 16'(bus_a.BUSY), 16'd1);
        chk("rst_busy_c", 16'(bus_c.BUSY), 16'd1);
        chk("rst_out_a",  16'(bus_a.OUT1), 16'h0);

        // Clear sequence; try to write 0xAA to r0 after it has been cleared.
        rst_a = 0; rst_b = 0; rst_c = 0;
        tick(2);
        bus_a.WRITE = 1; bus_a.INADDRESS = 0; bus_a.IN = 8'hAA;
        bus_a.OUT1ADDRESS = 0;
        #1;
        chk("busy_out_zero", 16'(bus_a.OUT1), 16'h0);
        tick(5);
        chk("clr7_busy_a", 16'(bus_a.BUSY), 16'd1);
        bus_a.WRITE = 0;
        tick();
        chk("clr8_busy_a", 16'(bus_a.BUSY), 16'd0);
        chk("clr8_busy_b", 16'(bus_b.BUSY), 16'd0);
        chk("clr8_busy_c", 16'(bus_c.BUSY), 16'd1);

        // Wider instance needs 32 edges.
        tick(23);
        chk("clr31_busy_c", 16'(bus_c.BUSY), 16'd1);
        tick();
        chk("clr32_busy_c", 16'(bus_c.BUSY), 16'd0);

        check_all_a("clr_a", 8'h00);

        // Write then read.
        write_a(3, 8'h5A);
        write_a(7, 8'hC3);
        bus_a.OUT1ADDRESS = 3; bus_a.OUT2ADDRESS = 7;
        #1;
        chk("wr_r3_p1", 16'(bus_a.OUT1), 16'h5A);
        chk("wr_r7_p2", 16'(bus_a.OUT2), 16'hC3);
        bus_a.OUT2ADDRESS = 3;
        #1;
        chk("same_r3_p1", 16'(bus_a.OUT1), 16'h5A);
        chk("same_r3_p2", 16'(bus_a.OUT2), 16'h5A);

        // Bypass enabled (A).
        write_a(2, 8'h11);
        bus_a.WRITE = 1; bus_a.INADDRESS = 2; bus_a.IN = 8'h22;
        bus_a.OUT1ADDRESS = 2; bus_a.OUT2ADDRESS = 3;
        #1;
        chk("byp1_pre", 16'(bus_a.OUT1), 16'h22);
        chk("byp1_other", 16'(bus_a.OUT2), 16'h5A);
        tick();
        bus_a.WRITE = 0;
        #1;
        chk("byp1_post", 16'(bus_a.OUT1), 16'h22);

        // Bypass disabled (B).
        bus_b.WRITE = 1; bus_b.INADDRESS = 2; bus_b.IN = 8'h11;
        tick();
        bus_b.IN = 8'h22; bus_b.OUT1ADDRESS = 2;
        #1;
        chk("byp0_pre", 16'(bus_b.OUT1), 16'h11);
        tick();
        bus_b.WRITE = 0;
        #1;
        chk("byp0_post", 16'(bus_b.OUT1), 16'h22);

        // Zero register (B): write 0xFF to r0.
        bus_b.WRITE = 1; bus_b.INADDRESS = 0; bus_b.IN = 8'hFF;
        bus_b.OUT1ADDRESS = 0; bus_b.OUT2ADDRESS = 0;
        #1;
        chk("zr_b_pre_p1", 16'(bus_b.OUT1), 16'h0);
        tick();
        bus_b.WRITE = 0;
        #1;
        chk("zr_b_post_p1", 16'(bus_b.OUT1), 16'h0);
        chk("zr_b_post_p2", 16'(bus_b.OUT2), 16'h0);

        // Zero register with bypass enabled (C), plus top-address write.
        bus_c.WRITE = 1; bus_c.INADDRESS = 0; bus_c.IN = 16'hFFFF;
        bus_c.OUT1ADDRESS = 0; bus_c.OUT2ADDRESS = 0;
        #1;
        chk("zr_c_byp", 16'(bus_c.OUT1), 16'h0);
        tick();
        bus_c.INADDRESS = 31; bus_c.IN = 16'hBEEF; bus_c.OUT2ADDRESS = 31;
        #1;
        chk("c_r31_byp", 16'(bus_c.OUT2), 16'hBEEF);
        chk("zr_c_post", 16'(bus_c.OUT1), 16'h0);
        tick();
        bus_c.WRITE = 0;
        #1;
        chk("c_r31_read", 16'(bus_c.OUT2), 16'hBEEF);

        // Entry 0 is an ordinary register on A.
        write_a(0, 8'hFF);
        bus_a.OUT1ADDRESS = 0; bus_a.OUT2ADDRESS = 0;
        #1;
        chk("r0_a_p1", 16'(bus_a.OUT1), 16'hFF);
        chk("r0_a_p2", 16'(bus_a.OUT2), 16'hFF);

        // Reset reasserted in the middle of a clear.
        for (int i = 0; i < 8; i++) write_a(3'(i), 8'hEE);
        bus_a.OUT1ADDRESS = 5;
        #1;
        chk("fill_r5", 16'(bus_a.OUT1), 16'hEE);
        rst_a = 1;
        tick();
        chk("mid_busy0", 16'(bus_a.BUSY), 16'd1);
        rst_a = 0;
        tick(3);
        rst_a = 1;
        tick();
        chk("mid_busy1", 16'(bus_a.BUSY), 16'd1);
        rst_a = 0;
        tick(7);
        chk("mid_busy7", 16'(bus_a.BUSY), 16'd1);
        tick();
        chk("mid_busy8", 16'(bus_a.BUSY), 16'd0);
        check_all_a("mid_a", 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_file_param

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the CPU's 8x8 register file.
- Provides configurable data width and depth, two asynchronous read ports and one synchronous write port.
- Adds optional same-cycle write-to-read bypass and an optional hardwired zero register.
- Reset is synchronous and clears one entry per cycle, reporting BUSY while it runs. Sits between the control unit/ALU datapath and the writeback path.

Parameters:
- DATA_W, 8: bits per register.
- ADDR_W, 3: address bits; DEPTH = 2**ADDR_W registers.
- BYPASS, 1: 1 = a read of the address being written this cycle returns IN; 0 = returns the stored value.
- ZERO_REG, 0: 1 = register 0 always reads 0 and ignores writes.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- WRITE  in  1  write enable, sampled at posedge.
- INADDRESS  in  ADDR_W  write address.
- IN  in  DATA_W  write data.
- OUT1ADDRESS  in  ADDR_W  read port 1 address.
- OUT2ADDRESS  in  ADDR_W  read port 2 address.
- OUT1  out  DATA_W  read port 1 data (combinational).
- OUT2  out  DATA_W  read port 2 data (combinational).
- BUSY  out  1  high while the clear sequence runs.

Behaviour:
- Reset is RESET, synchronous, active-high; clock is CLK.
- State machine: IDLE, CLEAR. Clear pointer ptr is ADDR_W bits wide.
- Reset edge: any posedge with RESET=1 sets state<=CLEAR and ptr<=0, with BUSY=1 from that edge.
  - No array writes occur while RESET is held.
  - Array contents are undefined before the first completed clear.
- CLEAR, RESET=0, each posedge: mem[ptr]<=0.
  - If ptr==DEPTH-1: state<=IDLE. Otherwise ptr<=ptr+1.
  - A full clear takes exactly DEPTH edges after RESET deasserts. BUSY falls on the DEPTH-th edge.
- RESET reasserted mid-clear: ptr restarts at 0 and the sequence restarts. Entries already cleared stay 0.
- BUSY is a registered output: 1 in CLEAR, 0 in IDLE.
- While BUSY=1:
  - OUT1 and OUT2 are forced to 0.
  - WRITE is ignored; the write is dropped, not queued.
- Write, IDLE: posedge with WRITE=1 performs mem[INADDRESS]<=IN.
  - Latency: the value is visible on the read ports from the following cycle.
  - If ZERO_REG=1 and INADDRESS==0, the write is dropped.
- Read: OUTn = mem[OUTnADDRESS] combinationally, with these overrides in priority order:
  1. BUSY=1 gives 0.
  2. ZERO_REG=1 and OUTnADDRESS==0 gives 0.
  3. BYPASS=1, WRITE=1 and OUTnADDRESS==INADDRESS gives IN.
- Both ports may read the same address and are independent of each other.
- Widths: no truncation or extension; IN, mem entries and OUTn are all DATA_W.
- Address wrap: ptr must not exceed DEPTH-1; the terminal compare is on DEPTH-1, not on overflow.
- No internal # delays. Any timing model is applied by the instantiating testbench only.

Decomposition:
- Package reg_file_pkg holds:
  - state typedef {IDLE, CLEAR};
  - default constants RF_DATA_W=8, RF_ADDR_W=3.
- Sub-module rf_read_port, instantiated twice, implements the per-port override and bypass mux. Inputs: mem data, address, IN, INADDRESS, WRITE, BUSY, parameters.
- The array, clear FSM and write logic stay in reg_file_param.

Test Plan:
- Clear timing: RESET=1 for 2 cycles, then 0 -> BUSY=1 for exactly 8 edges after deassert. Reads of all 8 addresses then return 0x00. WRITE=1 of 0xAA during BUSY -> address still reads 0x00 after clear.
- Write then read: write 0x5A to r3, 0xC3 to r7 -> next cycle OUT1ADDRESS=3 gives 0x5A and OUT2ADDRESS=7 gives 0xC3. Both ports on r3 -> both 0x5A.
- Bypass: r2 holds 0x11; WRITE=1, INADDRESS=2, IN=0x22, OUT1ADDRESS=2 in the same cycle.
  - BYPASS=1 -> OUT1=0x22 before the edge.
  - BYPASS=0 -> OUT1=0x11 before the edge and 0x22 after.
- Zero register: ZERO_REG=1; write 0xFF to r0 -> r0 reads 0x00 on both ports, including the bypass cycle. The same write with ZERO_REG=0 -> r0 reads 0xFF.
- Reset mid-clear: fill all registers with 0xEE, pulse RESET, then reassert RESET 3 cycles after deassert -> BUSY stays high and a full 8-edge clear follows the final deassert. All registers read 0x00.
- Parametrisation: DATA_W=16, ADDR_W=5 -> clear takes 32 edges; write 0xBEEF to r31 and read it back as 0xBEEF.
